fir_stream_sequencer: RTL and testbench
=======================================

# fir_stream_sequencer

Valid/ready stream front-end and sequencer for the 16-bit FIR datapath. It accepts input samples over a handshake and issues exactly one `data_in_clk` strobe per sample. It captures the filter output one cycle after each strobe and buffers results in a small FIFO toward a back-pressured output stream. It sits between the AXI stream slave logic and the FIR instance, and is the only driver of the FIR's `data_in_clk` and `data_in`.

## Interface
- `NUM_TAPS`, 49: tap count of the driven filter; sets the flush length.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `MIN_GAP`, 0: idle cycles inserted after each capture before the next sample is accepted; range 0..255.

- `clk  in  1`: system clock.
- `reset  in  1`: synchronous, active-low; clock clk.
- `s_valid  in  1`: input sample valid.
- `s_ready  out  1`: sequencer can accept a sample.
- `s_data  in  16`: signed input sample.
- `m_valid  out  1`: filtered result available.
- `m_ready  in  1`: downstream accepts the result.
- `m_data  out  16`: signed filtered result.
- `fir_en  out  1`: drives the FIR `data_in_clk`; one-cycle pulses only.
- `fir_din  out  16`: drives the FIR `data_in`.
- `fir_dout  in  16`: FIR `data_out`.
- `flush_req  in  1`: single-cycle request to drain filter history.
- `busy  out  1`: high in any state other than IDLE.
- `flush_busy  out  1`: high while a flush is running.

## Operation
- Reset (`reset`=0) forces the following values, evaluated at the next edge:
  - state=IDLE; FIFO emptied.
  - `s_ready`=0, `m_valid`=0, `m_data`=0, `fir_en`=0, `fir_din`=0, `busy`=0, `flush_busy`=0.
  - An in-flight sample is discarded.
- FSM states: IDLE, STROBE, CAPTURE, GAP, FLUSH.
- IDLE: `s_ready`=1 iff FIFO count < FIFO_DEPTH and `flush_req`=0.
  - If `flush_req`=1 (macro enabled), go to FLUSH. Flush has priority over a simultaneous `s_valid`.
  - Otherwise, on `s_valid`&&`s_ready`, latch `s_data` into `fir_din` and go to STROBE.
- STROBE: `fir_en`=1 for exactly this cycle; `fir_din` holds the sample. Go to CAPTURE.
- CAPTURE: push `fir_dout` into the FIFO at the end of this cycle. Go to GAP if MIN_GAP>0, else IDLE.
  - Space for the push is guaranteed, because the count was checked at accept and can only fall in between.
- GAP: count MIN_GAP cycles, then go to IDLE.
- FLUSH: `fir_din`=0 and `fir_en`=1 for NUM_TAPS+1 consecutive cycles. No results are pushed. Then go to IDLE.
- Result FIFO is first-word-fall-through:
  - `m_data` is stable while `m_valid`&&!`m_ready`.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - Push into an empty FIFO: `m_valid` rises the next cycle; there is no bypass path.
- Sign and width: `fir_din` is passed unmodified; `fir_dout` is stored unmodified, 16 bits, no rounding or saturation.

## Timing
- Input handshake at edge 0. `fir_en`=1 in cycle 1. FIFO write at the end of cycle 2. `m_valid`=1 in cycle 3 if the FIFO was empty and not stalled.
- Next `s_ready` in cycle 3+MIN_GAP. Sustained throughput is one sample per 3+MIN_GAP cycles.
- `fir_en` is never high on two consecutive cycles outside FLUSH.
- Flush occupies exactly NUM_TAPS+1 cycles with `flush_busy`=1. `s_ready`=0 throughout, and `m_*` continues draining.
- `flush_req` is ignored outside IDLE; it is not queued.
- `busy` is combinational from state.

## Configuration
- `FIR_SEQ_FLUSH_EN` defined: the FLUSH state and its counter are built as described above.
- Undefined: `flush_req` is ignored, `flush_busy` is tied to 0, and the FLUSH state and counter are not built.

## Structure
- Package `fir_seq_pkg` holds:
  - the state enum (IDLE/STROBE/CAPTURE/GAP/FLUSH);
  - default constants for NUM_TAPS=49 and FIFO_DEPTH=4;
  - the data width constant (16).
- Sub-module `fir_seq_fifo`: synchronous FWFT FIFO with parameters DEPTH and WIDTH. It exposes push/pop/count/full/empty and uses the same reset.
- The top level contains the FSM, the gap/flush counter, and the sample register.

## Test plan
- Reset with `s_valid`=1 → `s_ready`=0, `fir_en`=0, `m_valid`=0. After release, `s_ready`=1 in the first IDLE cycle.
- Send one sample 0x1234 with the bench FIR stub driving `fir_dout`=0x0ABC in cycle 2 → `fir_en` pulses only in cycle 1 with `fir_din`=0x1234; `m_data`=0x0ABC with `m_valid`=1 in cycle 3.
- Hold `m_ready`=0 and stream 6 samples with FIFO_DEPTH=4 → exactly 4 accepted and `s_ready` stays 0. Raise `m_ready` → results drain in order and the remaining 2 are accepted.
- MIN_GAP=5 with `s_valid` held high → `fir_en` pulses are spaced exactly 8 cycles apart.
- `FIR_SEQ_FLUSH_EN` defined: `flush_req` and `s_valid` asserted in the same IDLE cycle → 50 consecutive `fir_en` cycles with `fir_din`=0, nothing pushed, then the sample is accepted. Macro undefined: the same stimulus gives normal acceptance and `flush_busy`=0.
- Drop `reset` during CAPTURE → nothing is pushed, FIFO count is 0, `m_valid`=0 next cycle, and the state returns to IDLE.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared types and default constants for the FIR stream sequencer.
// The sequencer top honours the FIR_SEQ_FLUSH_EN build macro.
package fir_seq_pkg;

    localparam int DATA_W         = 16;
    localparam int DEF_NUM_TAPS   = 49;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_CAPTURE,
        ST_GAP,
        ST_FLUSH
    } seq_state_t;

endpackage

// File: rtl/fir_seq_fifo.sv
// Synchronous first-word-fall-through FIFO for filter results.
// Head entry is visible on pop_data whenever the FIFO is non-empty.
module fir_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fir_stream_sequencer.sv
// Valid/ready front-end that strobes the FIR once per accepted sample and queues its outputs.
// Define FIR_SEQ_FLUSH_EN to build the history-flush state and its counter.
module fir_stream_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NUM_TAPS   = DEF_NUM_TAPS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MIN_GAP    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     fir_en,
    output logic signed [DATA_W-1:0] fir_din,
    input  logic signed [DATA_W-1:0] fir_dout,
    input  logic                     flush_req,
    output logic                     busy,
    output logic                     flush_busy
);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_MAX = (NUM_TAPS > MIN_GAP) ? NUM_TAPS : MIN_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_sample;
    logic             clear_din;
    logic             flush_go;

    logic             fifo_push;
    logic             fifo_pop;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef FIR_SEQ_FLUSH_EN
    assign flush_go = flush_req;
`else
    logic unused_flush_req;
    assign unused_flush_req = flush_req;
    assign flush_go         = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        load_sample = 1'b0;
        clear_din   = 1'b0;
        s_ready     = 1'b0;
        fir_en      = 1'b0;
        flush_busy  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Held low during reset so nothing is taken while the FSM is being cleared.
                s_ready = reset && (int'(fifo_count) < FIFO_DEPTH) && !flush_go;
`ifdef FIR_SEQ_FLUSH_EN
                if (flush_go) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = CNT_W'(NUM_TAPS);
                    clear_din = 1'b1;
                end else
`endif
                if (s_valid && s_ready) begin
                    load_sample = 1'b1;
                    state_nxt   = ST_STROBE;
                end
            end
            ST_STROBE: begin
                fir_en    = 1'b1;
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (MIN_GAP > 0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = CNT_W'(MIN_GAP - 1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
`ifdef FIR_SEQ_FLUSH_EN
            ST_FLUSH: begin
                // Counter was loaded with NUM_TAPS, giving NUM_TAPS+1 zero strobes.
                fir_en     = 1'b1;
                flush_busy = 1'b1;
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            fir_din <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_sample)    fir_din <= s_data;
            else if (clear_din) fir_din <= '0;
        end
    end

    assign busy = (state != ST_IDLE);

    // Filter output is valid the cycle after the strobe; a reset in that cycle drops it.
    assign fifo_pop  = m_ready && m_valid;
    assign fifo_push = (state == ST_CAPTURE) && reset && (!fifo_full || fifo_pop);
    assign m_valid   = !fifo_empty;

    fir_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fir_dout),
        .pop       (fifo_pop),
        .pop_data  (m_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Scoreboard bench for fir_stream_sequencer with a small FIR stub; honours FIR_SEQ_FLUSH_EN.
// A second instance with MIN_GAP=5 covers the idle-gap spacing.
`timescale 1ns/1ps
module tb_fir_stream_sequencer;
    localparam int TAPS  = 49;
    localparam int DEPTH = 4;
    localparam int GAP   = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        s_valid = 1'b0, m_ready = 1'b1, flush_req = 1'b0;
    logic        s_ready, m_valid, fir_en, busy, flush_busy;
    logic [15:0] s_data = '0;
    logic [15:0] m_data, fir_din, fir_dout;

    logic        s_valid_g = 1'b0;
    logic        s_ready_g, m_valid_g, fir_en_g, busy_g, flush_busy_g;
    logic [15:0] s_data_g = '0;
    logic [15:0] m_data_g, fir_din_g;

    int n_cmp = 0, n_fail = 0, cyc = 0, acc_cnt = 0;

    fir_stream_sequencer #(.NUM_TAPS(TAPS), .FIFO_DEPTH(DEPTH), .MIN_GAP(0)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .fir_en(fir_en),
        .fir_din(fir_din), .fir_dout(fir_dout), .flush_req(flush_req), .busy(busy),
        .flush_busy(flush_busy)
    );

    fir_stream_sequencer #(.NUM_TAPS(TAPS), .FIFO_DEPTH(DEPTH), .MIN_GAP(GAP)) dut_g (
        .clk(clk), .reset(reset), .s_valid(s_valid_g), .s_ready(s_ready_g), .s_data(s_data_g),
        .m_valid(m_valid_g), .m_ready(1'b1), .m_data(m_data_g), .fir_en(fir_en_g),
        .fir_din(fir_din_g), .fir_dout(fir_din_g), .flush_req(1'b0), .busy(busy_g),
        .flush_busy(flush_busy_g)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // FIR stub: y = x[n] + 2*x[n-1] - x[n-2], advanced once per strobe.
    function automatic logic [15:0] tap_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
        return a + {b[14:0], 1'b0} - c;
    endfunction

    logic [15:0] h0 = '0, h1 = '0, stub_out = '0, ov_val = '0;
    logic        ov_en = 1'b0;
    always @(posedge clk) begin
        if (fir_en) begin
            h1       <= h0;
            h0       <= fir_din;
            stub_out <= tap_fn(fir_din, h0, h1);
        end
    end
    assign fir_dout = ov_en ? ov_val : stub_out;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail_msg(input string nm, input string act, input string req);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %s, expected %s (t=%0t)", nm, act, req, $time);
    endtask

    // Reference model: every accepted sample is one filter step, in order.
    typedef struct { int c; logic [15:0] d; } stb_t;
    logic [15:0] exp_q [$];
    logic [15:0] exp_g [$];
    stb_t        stb_q [$];
    logic [15:0] mh0 = '0, mh1 = '0, e_val, hold_data;
    logic        hold_prev = 1'b0, g_on = 1'b0;
    int          last_g = -1, n_g = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                stb_q.delete();
                exp_g.delete();
                hold_prev = 1'b0;
            end else begin
                if (stb_q.size() > 0 && stb_q[0].c == cyc) begin
                    chk("strobe_en", {31'd0, fir_en}, 32'd1);
                    chk("strobe_din", {16'd0, fir_din}, {16'd0, stb_q[0].d});
                    void'(stb_q.pop_front());
                end else if (fir_en && !flush_busy) begin
                    fail_msg("stray_strobe", $sformatf("fir_en=1 at cycle %0d", cyc), "fir_en=0");
                end
                if (hold_prev) begin
                    chk("m_hold_valid", {31'd0, m_valid}, 32'd1);
                    chk("m_hold_data", {16'd0, m_data}, {16'd0, hold_data});
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0)
                        fail_msg("unexpected_result", $sformatf("0x%0h", m_data), "no result");
                    else
                        chk("result", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
                end
                hold_prev = m_valid && !m_ready;
                hold_data = m_data;
                if (s_valid && s_ready) begin
                    e_val = ov_en ? ov_val : tap_fn(s_data, mh0, mh1);
                    mh1   = mh0;
                    mh0   = s_data;
                    exp_q.push_back(e_val);
                    stb_q.push_back('{cyc + 1, s_data});
                    acc_cnt++;
                end
                if (m_valid_g) begin
                    if (exp_g.size() == 0)
                        fail_msg("gap_unexpected", $sformatf("0x%0h", m_data_g), "no result");
                    else
                        chk("gap_result", {16'd0, m_data_g}, {16'd0, exp_g.pop_front()});
                end
                if (s_valid_g && s_ready_g) exp_g.push_back(s_data_g);
                if (fir_en_g && g_on) begin
                    if (last_g >= 0) chk("gap_spacing", cyc - last_g, GAP + 3);
                    last_g = cyc;
                    n_g++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [15:0] d, output int acc);
        bit got = 1'b0;
        acc     = -1;
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1'b1;
                acc = cyc;
                break;
            end
        end
        if (!got) fail_msg("send_timeout", "no s_ready", "s_ready within 300 cycles");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_g.size() == 0 && !m_valid && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_msg(nm, $sformatf("%0d results pending", exp_q.size()), "drained");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  a, base, n, bad_din, bad_rdy, k;
        bit  got;
        bit  rnd_done;

        s_valid = 1'b1;
        s_data  = 16'h7777;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_fir_en", {31'd0, fir_en}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {16'd0, m_data}, 32'd0);
        chk("rst_fir_din", {16'd0, fir_din}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rel_s_ready", {31'd0, s_ready}, 32'd1);

        // Single sample with the stub forced to 0x0ABC.
        @(posedge clk);
        #1;
        ov_en  = 1'b1;
        ov_val = 16'h0ABC;
        send(16'h1234, a);
        @(negedge clk);
        chk("t1_strobe_cycle", cyc, a + 1);
        chk("t1_fir_en", {31'd0, fir_en}, 32'd1);
        chk("t1_fir_din", {16'd0, fir_din}, 32'h1234);
        @(negedge clk);
        chk("t1_m_valid_c2", {31'd0, m_valid}, 32'd0);
        chk("t1_fir_en_c2", {31'd0, fir_en}, 32'd0);
        @(negedge clk);
        chk("t1_m_valid_c3", {31'd0, m_valid}, 32'd1);
        chk("t1_m_data_c3", {16'd0, m_data}, 32'h0ABC);
        chk("t1_s_ready_c3", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        ov_en = 1'b0;
        drain("drain_t1");

        // MIN_GAP=5 instance with s_valid held high.
        g_on      = 1'b1;
        s_valid_g = 1'b1;
        s_data_g  = 16'($urandom);
        for (int i = 0; i < 6; i++) begin
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (s_ready_g) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) fail_msg("gap_accept_timeout", "no s_ready", "s_ready within 20 cycles");
            @(posedge clk);
            #1;
            s_data_g = 16'($urandom);
        end
        s_valid_g = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("gap_pulses", n_g, 6);
        chk("gap_busy_idle", {31'd0, busy_g}, 32'd0);
        chk("gap_flush_busy", {31'd0, flush_busy_g}, 32'd0);
        g_on = 1'b0;

        // Back-pressure: 6 samples offered, only DEPTH fit while m_ready is low.
        m_ready = 1'b0;
        base    = acc_cnt;
        fork
            begin
                int ab;
                for (int i = 0; i < 6; i++) send(16'($urandom), ab);
            end
        join_none
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_accepts", acc_cnt - base, DEPTH);
        chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
        chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait fork;
        drain("drain_bp");
        chk("bp_total", acc_cnt - base, 6);

        // Randomised traffic with random back-pressure.
        rnd_done = 1'b0;
        fork
            begin
                int ar;
                for (int i = 0; i < 120; i++) begin
                    k = $urandom_range(0, 2);
                    repeat (k) begin
                        @(posedge clk);
                        #1;
                    end
                    send(16'($urandom), ar);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
                m_ready = 1'b1;
            end
        join
        drain("drain_random");

        // Flush request together with a sample in IDLE.
        base      = acc_cnt;
        flush_req = 1'b1;
        s_valid   = 1'b1;
        s_data    = 16'h4321;
`ifdef FIR_SEQ_FLUSH_EN
        @(negedge clk);
        chk("fl_prio_s_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        n       = 0;
        bad_din = 0;
        bad_rdy = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (fir_en && flush_busy) begin
                if (n == 0) begin
                    mh0 = '0;
                    mh1 = '0;
                end
                n++;
                if (fir_din != 16'd0) bad_din++;
                if (s_ready) bad_rdy++;
            end else begin
                break;
            end
        end
        chk("fl_len", n, TAPS + 1);
        chk("fl_din_zero", bad_din, 0);
        chk("fl_s_ready_low", bad_rdy, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("fl_accept", acc_cnt - base, 1);
`else
        @(negedge clk);
        chk("nofl_s_ready", {31'd0, s_ready}, 32'd1);
        chk("nofl_flush_busy", {31'd0, flush_busy}, 32'd0);
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        s_valid   = 1'b0;
        repeat (3) @(negedge clk);
        chk("nofl_accept", acc_cnt - base, 1);
        chk("nofl_flush_busy_after", {31'd0, flush_busy}, 32'd0);
`endif
        drain("drain_flush");

        // Reset asserted during CAPTURE drops the in-flight result.
        send(16'h5A5A, a);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rc_in_capture", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rc_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rc_busy", {31'd0, busy}, 32'd0);
        chk("rc_s_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rc_s_ready_after", {31'd0, s_ready}, 32'd1);
        chk("rc_m_valid_after", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(16'($urandom), a);
        drain("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
